bank_write_arbiter: RTL

BANK_WRITE_ARBITER -- requirements
Module: bank_write_arbiter

---
 rtl/bank_write_arbiter_pkg.sv | 12 +
 rtl/rr_arbiter2.sv | 21 ++
 rtl/bank_write_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/bank_write_arbiter_pkg.sv
// Shared types and default widths for the bank write arbiter and the bank it feeds.
package bank_write_arbiter_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_ADDRESS_WIDTH = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin selector: purely combinational readies from valids
// and the last-granted pointer.
module rr_arbiter2 (
  input  logic       en,
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] ready,
  output logic       winner
);

  always_comb begin
    ready = 2'b00;
    if (en) begin
      // on contention the requester that did not win last time takes the slot
      if (valid == 2'b11) ready = last ? 2'b01 : 2'b10;
      else                ready = valid;
    end
    winner = ready[1];
  end

endmodule

// File: rtl/bank_write_arbiter.sv
// Clears the bank after reset, then arbitrates two write requesters onto a
// single registered bank write port with one cycle of latency.
module bank_write_arbiter
  import bank_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  input  logic [ADDRESS_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0]    req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [ADDRESS_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0]    req1_data,
  output logic                     req1_ready,
  output logic                     bank_write,
  output logic [ADDRESS_WIDTH-1:0] bank_addr_in,
  output logic [DATA_WIDTH-1:0]    bank_data_in,
  output logic                     init_done,
  output logic                     grant_id
);

  localparam int                   DEPTH   = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] CLR_END = DEPTH[ADDRESS_WIDTH:0];
  localparam logic [ADDRESS_WIDTH:0] CNT_ONE = (ADDRESS_WIDTH+1)'(1);

  state_t                               state, state_nxt;
  logic [ADDRESS_WIDTH:0]               clr_cnt;
  logic                                 clr_last;
  logic                                 arb_en;
  logic                                 last_grant;
  logic                                 winner;
  logic                                 hs;
  logic [1:0]                           valid, ready;
  logic [1:0][ADDRESS_WIDTH-1:0]        addr;
  logic [1:0][DATA_WIDTH-1:0]           data;

  assign valid = {req1_valid, req0_valid};
  assign addr  = {req1_addr,  req0_addr};
  assign data  = {req1_data,  req0_data};

  // counter runs one past the last address so that address stays visible for a full CLEAR cycle
  assign clr_last = (clr_cnt == CLR_END);

  rr_arbiter2 u_arb (
    .en     (arb_en),
    .valid  (valid),
    .last   (last_grant),
    .ready  (ready),
    .winner (winner)
  );

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign hs         = |(valid & ready);
  assign init_done  = (state == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arb_en    = 1'b0;
    case (state)
      CLEAR: if (clr_last) state_nxt = RUN;
      RUN:   arb_en = 1'b1;
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_cnt      <= '0;
      bank_write   <= 1'b0;
      bank_addr_in <= '0;
      bank_data_in <= '0;
      grant_id     <= 1'b0;
      last_grant   <= 1'b1;
    end else if (state == CLEAR) begin
      bank_write <= !clr_last;
      if (!clr_last) begin
        bank_addr_in <= clr_cnt[ADDRESS_WIDTH-1:0];
        bank_data_in <= '0;
        clr_cnt      <= clr_cnt + CNT_ONE;
      end
    end else begin
      // idle cycles drop the strobe but leave address/data parked
      bank_write <= hs;
      if (hs) begin
        bank_addr_in <= addr[winner];
        bank_data_in <= data[winner];
        grant_id     <= winner;
        last_grant   <= winner;
      end
    end
  end

endmodule
